// File: rtl/regfile_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// regfile_seq_pkg
// Shared definitions for the register-file instruction sequencer:
//   - opcode constants (ADD / ADDI / OUT / SUB)
//   - FSM state encoding (IDLE / READ / EXEC / WB)
//   - instruction field positions and small field-extraction helpers
// Instruction format: [7:6] op, [5:4] rs, [3:2] rt, [1:0] rd / imm.
// ----------------------------------------------------------------------------
package regfile_seq_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_OUT  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    localparam int INSTR_W = 8;
    localparam int OP_LSB  = 6;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 2;
    localparam int RD_LSB  = 0;

    function automatic logic [1:0] instr_op(input logic [INSTR_W-1:0] i);
        return i[OP_LSB +: 2];
    endfunction

    function automatic logic [1:0] instr_rs(input logic [INSTR_W-1:0] i);
        return i[RS_LSB +: 2];
    endfunction

    function automatic logic [1:0] instr_rt(input logic [INSTR_W-1:0] i);
        return i[RT_LSB +: 2];
    endfunction

    // Low field doubles as rd (ADD/SUB) and 2-bit signed immediate (ADDI).
    function automatic logic [1:0] instr_rd(input logic [INSTR_W-1:0] i);
        return i[RD_LSB +: 2];
    endfunction

endpackage

// File: rtl/regfile_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// regfile_seq_ctrl_if
// Bundles the instruction handshake and the register-file port signals.
//   instr / instr_valid / instr_ready : instruction source handshake
//   rr1 / rr2 / rd1 / rd2             : register-file read ports
//   write / wr / wd                   : register-file write port
// Modports:
//   master : the sequencer (drives ready, read addresses, write port)
//   slave  : instruction source plus register file (the environment)
// ----------------------------------------------------------------------------
interface regfile_seq_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic [7:0]        instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] rr1;
    logic [ADDR_W-1:0] rr2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              write;
    logic [ADDR_W-1:0] wr;
    logic [DATA_W-1:0] wd;

    modport master (
        input  instr, instr_valid, rd1, rd2,
        output instr_ready, rr1, rr2, write, wr, wd
    );

    modport slave (
        output instr, instr_valid, rd1, rd2,
        input  instr_ready, rr1, rr2, write, wr, wd
    );
endinterface

// File: rtl/regfile_seq_ctrl_alu.sv
// ----------------------------------------------------------------------------
// seq_alu
// Combinational ALU for the sequencer.
//   a, b : operands (register read data rs / rt)
//   op   : opcode
//   imm  : 2-bit signed immediate (ADDI only)
//   y    : result (wraps at DATA_W bits)
//   c    : carry out of the add (ADD/ADDI) or borrow of the subtract (SUB);
//          0 for OUT, where the caller keeps the previous carry anyway.
// ----------------------------------------------------------------------------
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    input  logic [1:0]        imm,
    output logic [DATA_W-1:0] y,
    output logic              c
);
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W:0]   full;

    assign imm_ext = {{(DATA_W-2){imm[1]}}, imm};

    always_comb begin
        full = {1'b0, a};
        case (op)
            OP_ADD:  full = {1'b0, a} + {1'b0, b};
            OP_ADDI: full = {1'b0, a} + {1'b0, imm_ext};
            // Wrapped 9-bit difference: top bit set exactly when a < b.
            OP_SUB:  full = {1'b0, a} - {1'b0, b};
            default: full = {1'b0, a};
        endcase
    end

    assign y = full[DATA_W-1:0];
    assign c = full[DATA_W];
endmodule

// File: rtl/regfile_seq_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_seq_ctrl
// Four-cycle instruction sequencer for a 4x8 2R/1W register file.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : instruction handshake + register-file ports (master side)
//   result       : last computed value
//   carry        : carry (ADD/ADDI) or borrow (SUB) of last arithmetic op
//   done         : one-cycle pulse in the write-back cycle
//   retired      : completed-instruction counter (wraps)
// Flow: IDLE (accept) -> READ (addresses out) -> EXEC (ALU registered)
//       -> WB (write port + done) -> IDLE.
// ----------------------------------------------------------------------------
module regfile_seq_ctrl
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    regfile_seq_ctrl_if.master bus,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              done,
    output logic [CNT_W-1:0]  retired
);
    logic [1:0]        state_q,   state_d;
    logic [7:0]        instr_q,   instr_d;
    logic [ADDR_W-1:0] rr1_q,     rr1_d;
    logic [ADDR_W-1:0] rr2_q,     rr2_d;
    logic              write_q,   write_d;
    logic [ADDR_W-1:0] wr_q,      wr_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic              carry_q,   carry_d;
    logic              done_q,    done_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [DATA_W-1:0] alu_y;
    logic              alu_c;

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .a   (bus.rd1),
        .b   (bus.rd2),
        .op  (instr_op(instr_q)),
        .imm (instr_rd(instr_q)),
        .y   (alu_y),
        .c   (alu_c)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        rr1_d     = rr1_q;
        rr2_d     = rr2_q;
        write_d   = 1'b0;
        wr_d      = wr_q;
        result_d  = result_q;
        carry_d   = carry_q;
        done_d    = 1'b0;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    // Addresses are loaded here so they are already on the
                    // bus during READ; they then hold through EXEC and WB.
                    rr1_d   = ADDR_W'(instr_rs(bus.instr));
                    rr2_d   = ADDR_W'(instr_rt(bus.instr));
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Read data has been stable since READ; capture the ALU
                // and set up the write-back registers for the WB cycle.
                result_d  = alu_y;
                if (instr_op(instr_q) != OP_OUT) begin
                    carry_d = alu_c;
                end
                write_d   = (instr_op(instr_q) != OP_OUT);
                wr_d      = (instr_op(instr_q) == OP_ADDI) ? ADDR_W'(instr_rt(instr_q))
                                                           : ADDR_W'(instr_rd(instr_q));
                done_d    = 1'b1;
                retired_d = retired_q + 1'b1;
                state_d   = ST_WB;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            rr1_q     <= '0;
            rr2_q     <= '0;
            write_q   <= 1'b0;
            wr_q      <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            rr1_q     <= rr1_d;
            rr2_q     <= rr2_d;
            write_q   <= write_d;
            wr_q      <= wr_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            done_q    <= done_d;
            retired_q <= retired_d;
        end
    end

    assign bus.instr_ready = (state_q == ST_IDLE);
    assign bus.rr1         = rr1_q;
    assign bus.rr2         = rr2_q;
    assign bus.write       = write_q;
    assign bus.wr          = wr_q;
    assign bus.wd          = result_q;

    assign result  = result_q;
    assign carry   = carry_q;
    assign done    = done_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_seq_ctrl
// Bench for regfile_seq_ctrl: a small register file is attached to the bus,
// an architectural model predicts each instruction's effect and timing, and
// directed sequences carry hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_regfile_seq_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] result;
    logic       carry;
    logic       done;
    logic [7:0] retired;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    regfile_seq_ctrl_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    regfile_seq_ctrl #(.DATA_W(8), .ADDR_W(2), .CNT_W(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .result  (result),
        .carry   (carry),
        .done    (done),
        .retired (retired)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Register file attached to the sequencer.
    logic [7:0] rf [4];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (bus.write) begin
            rf[bus.wr] <= bus.wd;
        end
    end
    assign bus.rd1 = rf[bus.rr1];
    assign bus.rd2 = rf[bus.rr2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- architectural model + per-cycle compare --------------
    int          m_regs [4];
    int          m_result  = 0;
    int          m_carry   = 0;
    int          m_retired = 0;
    int unsigned next_free = 0;
    bit          pend_valid = 0;
    int unsigned pend_acc, pend_due;
    int          pend_rs, pend_rt, pend_wr, pend_val, pend_carry;
    bit          pend_write;

    always @(negedge clock) begin
        bit exp_ready, exp_done, exp_write;
        if (reset) begin
            chk("rst_ready",   bus.instr_ready, 1);
            chk("rst_write",   bus.write, 0);
            chk("rst_wr",      bus.wr, 0);
            chk("rst_wd",      bus.wd, 0);
            chk("rst_rr1",     bus.rr1, 0);
            chk("rst_rr2",     bus.rr2, 0);
            chk("rst_result",  result, 0);
            chk("rst_carry",   carry, 0);
            chk("rst_done",    done, 0);
            chk("rst_retired", retired, 0);
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            m_result = 0; m_carry = 0; m_retired = 0;
            pend_valid = 0; next_free = 0;
        end else begin
            exp_ready = (cyc >= next_free);
            exp_done  = pend_valid && (cyc == pend_due);
            exp_write = exp_done && pend_write;
            if (exp_done) begin
                m_result  = pend_val;
                if (pend_write || pend_rs < 0) m_carry = pend_carry;
                m_retired = (m_retired + 1) % 256;
            end
            chk("ready",   bus.instr_ready, exp_ready);
            chk("done",    done, exp_done);
            chk("write",   bus.write, exp_write);
            chk("result",  result, m_result);
            chk("carry",   carry, m_carry);
            chk("retired", retired, m_retired);
            if (pend_valid && cyc > pend_acc) begin
                chk("rr1", bus.rr1, pend_rs);
                chk("rr2", bus.rr2, pend_rt);
            end
            if (exp_write) begin
                chk("wr", bus.wr, pend_wr);
                chk("wd", bus.wd, pend_val);
                m_regs[pend_wr] = pend_val;
            end
            if (exp_done) pend_valid = 0;
            if (exp_ready && bus.instr_valid) begin
                int op, a, b, imm, sum;
                op  = bus.instr[7:6];
                pend_rs = bus.instr[5:4];
                pend_rt = bus.instr[3:2];
                a   = m_regs[pend_rs];
                b   = m_regs[pend_rt];
                imm = (bus.instr[1:0] >= 2) ? bus.instr[1:0] - 4 : bus.instr[1:0];
                pend_write = (op != 2);
                pend_wr    = (op == 1) ? pend_rt : bus.instr[1:0];
                case (op)
                    0: sum = a + b;
                    1: sum = a + ((imm + 256) % 256);
                    3: sum = a - b;
                    default: sum = a;
                endcase
                pend_val   = (sum + 512) % 256;
                pend_carry = (op == 3) ? int'(a < b) : int'(sum > 255);
                pend_acc   = cyc;
                pend_due   = cyc + 3;
                next_free  = cyc + 4;
                pend_valid = 1;
            end
        end
    end

    // Done-pulse timestamps for the streaming test.
    bit          collect = 0;
    int unsigned done_cycles [$];
    always @(negedge clock) if (collect && !reset && done) done_cycles.push_back(cyc);

    // ---------------- directed stimulus with literal expectations ---------
    // Called at #1 after a rising edge in an idle cycle; issues one
    // instruction for one cycle and checks the WB cycle and the idle after.
    task automatic send(input logic [7:0] ins, input bit exp_write, input int exp_wr,
                        input int exp_res, input int exp_carry, input int exp_ret);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        @(posedge clock); #1;
        bus.instr_valid = 1'b0;
        bus.instr = 8'hFF;              // garbage while busy, must be ignored
        @(posedge clock);
        @(posedge clock); #2;
        chk("lit_done",    done, 1);
        chk("lit_write",   bus.write, exp_write);
        if (exp_write) begin
            chk("lit_wr", bus.wr, exp_wr);
            chk("lit_wd", bus.wd, exp_res);
        end
        chk("lit_result",  result, exp_res);
        chk("lit_carry",   carry, exp_carry);
        chk("lit_retired", retired, exp_ret);
        @(posedge clock); #1;
        chk("lit_ready_after", bus.instr_ready, 1);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] stream [4];
        int idx;
        bit acc;
        stream[0] = 8'h45; stream[1] = 8'h59; stream[2] = 8'h27; stream[3] = 8'hB0;
        bus.instr = 8'h00;
        bus.instr_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Single-issue sequence.
        send(8'h45, 1, 1, 8'h01, 0, 1);   // ADDI r1 = r0 + 1
        send(8'h16, 1, 2, 8'h02, 0, 2);   // ADD  r2 = r1 + r1
        send(8'h6F, 1, 3, 8'h01, 1, 3);   // ADDI r3 = r2 - 1
        send(8'hC7, 1, 3, 8'hFF, 1, 4);   // SUB  r3 = r0 - r1 (borrow)
        send(8'h90, 0, 0, 8'h01, 1, 5);   // OUT  r1, carry kept

        // Valid held high across four queued instructions.
        do_reset();
        collect = 1;
        idx = 0;
        bus.instr = stream[0];
        bus.instr_valid = 1'b1;
        for (int n = 0; n < 40 && idx < 4; n++) begin
            @(negedge clock);
            acc = bus.instr_ready && bus.instr_valid;
            @(posedge clock); #1;
            if (acc) begin
                idx++;
                if (idx < 4) bus.instr = stream[idx];
                else bus.instr_valid = 1'b0;
            end
        end
        chk("stream_accepts", idx, 4);
        repeat (4) @(posedge clock);
        #2;
        collect = 0;
        chk("stream_retired", retired, 4);
        chk("stream_result",  result, 8'h03);
        chk("stream_dones",   done_cycles.size(), 4);
        for (int i = 1; i < done_cycles.size(); i++)
            chk("stream_spacing", done_cycles[i] - done_cycles[i-1], 4);

        // Reset during EXEC of an ADD.
        do_reset();
        bus.instr = 8'h16;
        bus.instr_valid = 1'b1;
        @(posedge clock); #1;           // now READ
        bus.instr_valid = 1'b0;
        @(posedge clock); #1;           // now EXEC
        reset = 1'b1;
        #1;
        chk("abort_write", bus.write, 0);
        chk("abort_ready", bus.instr_ready, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("abort_ready_after", bus.instr_ready, 1);
        chk("abort_retired",     retired, 0);
        repeat (5) @(posedge clock);
        #2;
        chk("abort_retired_late", retired, 0);
        chk("abort_write_late",   bus.write, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
